llr_stage: RTL and testbench
============================

LLR_STAGE -- requirements
Module: llr_stage

Interface
REQ-001 Parameter MW, 16, metric width of alpha/beta/channel inputs and LLR output.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  one trellis step of operands present this cycle.
REQ-005 in_last  input  1  qualifies in_valid; final step of the block.
REQ-006 count_main  input  8  trellis step index of current operands.
REQ-007 a0..a7  input  MW signed each  forward metrics alpha[s] for step k.
REQ-008 b0..b7  input  MW signed each  backward metrics beta[s] for step k+1, from backward recursion.
REQ-009 ls, lp  input  MW signed each  systematic and parity channel LLRs for step k.
REQ-010 llr  output  MW signed  a-posteriori LLR of bit k.
REQ-011 hard_bit  output  1  1 when llr > 0, else 0.
REQ-012 llr_valid  output  1  llr/hard_bit/llr_addr valid this cycle.
REQ-013 llr_addr  output  8  count_main carried with the result.
REQ-014 done_llr  output  1  one-cycle pulse with the final llr_valid of a block.
REQ-015 busy  output  1  high in RUN and FLUSH.
REQ-016 err_overrun  output  1  sticky; in_valid received in FLUSH.

Function
REQ-017 Trellis: 8-state RSC, feedback 1+D^2+D^3, forward 1+D+D^3; next-state and parity per (state, u) from package function.
REQ-018 Branch metric gamma(u,p) = (u ? ls : -ls) + (p ? lp : -lp), MW+1 bits signed.
REQ-019 Path sum per transition = alpha[s] + gamma + beta[next(s,u)], sign-extended to MW+2 bits; no wrap.
REQ-020 llr = max over 8 u=1 sums minus max over 8 u=0 sums, MW+3 bits internally, then reduced per REQ-030/031.
REQ-021 Pipeline: S1 registers inputs and gammas; S2 forms 16 sums and 4-way partial maxima; S3 final max, subtract, reduce.
REQ-022 Latency exactly 3 cycles from in_valid to llr_valid; throughput one step per cycle; no backpressure.
REQ-023 FSM states IDLE, RUN, FLUSH; IDLE->RUN on in_valid; RUN->FLUSH on in_valid&in_last; FLUSH->IDLE when last result leaves S3.
REQ-024 in_valid&in_last in IDLE: step processed, FSM goes directly to FLUSH.
REQ-025 in_valid in FLUSH: operands dropped, err_overrun set until reset.
REQ-026 done_llr asserted in the same cycle as the llr_valid of the in_last step, never otherwise.
REQ-027 Outputs llr, hard_bit, llr_addr hold last value while llr_valid low.

Reset
REQ-028 rst low: FSM to IDLE, all pipeline valids cleared, llr=0, hard_bit=0, llr_addr=0, llr_valid=0, done_llr=0, busy=0, err_overrun=0, immediately and asynchronously.
REQ-029 Reset mid-block discards all in-flight steps; no llr_valid or done_llr for them after release.

Configuration
REQ-030 LLR_SAT_EN defined: MW+3-bit result clamped to [-(2^(MW-1)), 2^(MW-1)-1].
REQ-031 LLR_SAT_EN undefined: result truncated to low MW bits (two's-complement wrap); hard_bit still from the untruncated sign.

Structure
REQ-032 Shared package llr_pkg holds NUM_STATES=8, next-state and parity functions, FSM state typedef, metric width constants.
REQ-033 One sub-module max8_tree (8-input signed max, one internal register stage) instantiated twice, for u=0 and u=1.

Verification
REQ-034 alpha=beta=0, ls=100, lp=0, in_valid at cycle 0 -> llr_valid at cycle 3, llr=200, hard_bit=1.
REQ-035 alpha=beta=0, ls=-50, lp=30 -> llr=-100, hard_bit=0.
REQ-036 alpha=beta=0, ls=lp=32767 -> LLR_SAT_EN: llr=32767; without: llr=-2 (0xFFFE), hard_bit=1.
REQ-037 8 back-to-back steps count_main 0..7, in_last on 7 -> 8 consecutive llr_valid, llr_addr 0..7, done_llr only with addr 7, busy falls after.
REQ-038 rst low at step 4 of 8 -> no further llr_valid/done_llr; fresh block after release decodes normally.
REQ-039 in_valid one cycle after in_last -> err_overrun=1 and held; that step produces no output.

Source files
------------

// File: rtl/llr_pkg.sv
// Shared definitions for the LLR stage: trellis of the 8-state RSC code,
// metric width defaults and the control FSM state type.
package llr_pkg;

  localparam int NUM_STATES = 8;
  localparam int MW_DEFAULT = 16;
  localparam int ADDR_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fsm_state_t;

  // State bit 0 is the most recent register (D), bit 2 the oldest (D^3).
  // Feedback 1+D^2+D^3, forward 1+D+D^3.
  function automatic logic [2:0] next_state(input logic [2:0] s, input logic u);
    logic fb;
    fb = u ^ s[1] ^ s[2];
    return {s[1], s[0], fb};
  endfunction

  function automatic logic parity(input logic [2:0] s, input logic u);
    logic fb;
    fb = u ^ s[1] ^ s[2];
    return fb ^ s[0] ^ s[2];
  endfunction

endpackage

// File: rtl/llr_stage_max8_tree.sv
// Eight-input signed maximum: two registered 4-way partial maxima followed
// by a combinational final compare.
module max8_tree
  import llr_pkg::*;
#(
  parameter int W = 18
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_STATES-1:0][W-1:0]      din,
  output logic signed [W-1:0]               dmax
);

  function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] x,
                                               input logic signed [W-1:0] y);
    return (x > y) ? x : y;
  endfunction

  logic signed [W-1:0] lo_d, hi_d, lo_q, hi_q;

  always_comb begin
    lo_d = smax(smax(din[0], din[1]), smax(din[2], din[3]));
    hi_d = smax(smax(din[4], din[5]), smax(din[6], din[7]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign dmax = smax(lo_q, hi_q);

endmodule

// File: rtl/llr_stage.sv
// Max-log-MAP a-posteriori LLR for one trellis step, 3-cycle pipeline.
// Define LLR_SAT_EN to clamp the result to MW bits instead of wrapping.
module llr_stage
  import llr_pkg::*;
#(
  parameter int MW = MW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [ADDR_W-1:0]        count_main,
  input  logic signed [MW-1:0]     a0, a1, a2, a3, a4, a5, a6, a7,
  input  logic signed [MW-1:0]     b0, b1, b2, b3, b4, b5, b6, b7,
  input  logic signed [MW-1:0]     ls,
  input  logic signed [MW-1:0]     lp,
  output logic signed [MW-1:0]     llr,
  output logic                     hard_bit,
  output logic                     llr_valid,
  output logic [ADDR_W-1:0]        llr_addr,
  output logic                     done_llr,
  output logic                     busy,
  output logic                     err_overrun,
  output fsm_state_t               fsm_state
);

  localparam int GW = MW + 1;
  localparam int SW = MW + 2;
  localparam int DW = MW + 3;

  logic signed [MW-1:0] a_in [NUM_STATES];
  logic signed [MW-1:0] b_in [NUM_STATES];

  assign a_in = '{a0, a1, a2, a3, a4, a5, a6, a7};
  assign b_in = '{b0, b1, b2, b3, b4, b5, b6, b7};

  // Handshake: no backpressure. in_valid is a single-cycle strobe taken
  // whenever the FSM is not in FLUSH; llr_valid is a single-cycle strobe.
  fsm_state_t state_q, state_d;
  logic       accept, overrun_hit;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    overrun_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = in_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          accept = 1'b1;
          if (in_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        overrun_hit = in_valid;
        if (done_llr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      err_overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_overrun <= err_overrun | overrun_hit;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign fsm_state = state_q;

  // Branch metrics indexed by {u, p}.
  logic signed [GW-1:0] ls_x, lp_x;
  logic signed [GW-1:0] gamma_d [4];

  assign ls_x = {ls[MW-1], ls};
  assign lp_x = {lp[MW-1], lp};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      gamma_d[i] = (i[1] ? ls_x : -ls_x) + (i[0] ? lp_x : -lp_x);
    end
  end

  // S1: operand and gamma registers.
  logic                 s1_valid, s1_last;
  logic [ADDR_W-1:0]    s1_addr;
  logic signed [MW-1:0] s1_a [NUM_STATES];
  logic signed [MW-1:0] s1_b [NUM_STATES];
  logic signed [GW-1:0] s1_g [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      for (int i = 0; i < NUM_STATES; i++) begin
        s1_a[i] <= '0;
        s1_b[i] <= '0;
      end
      for (int i = 0; i < 4; i++) s1_g[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_last <= in_last;
        s1_addr <= count_main;
        s1_a    <= a_in;
        s1_b    <= b_in;
        s1_g    <= gamma_d;
      end
    end
  end

  function automatic logic [SW-1:0] path_sum(input logic signed [MW-1:0] a,
                                             input logic signed [GW-1:0] g,
                                             input logic signed [MW-1:0] b);
    logic signed [SW-1:0] ae, ge, be;
    ae = {{2{a[MW-1]}}, a};
    ge = {g[GW-1], g};
    be = {{2{b[MW-1]}}, b};
    return ae + ge + be;
  endfunction

  // S2: sixteen path sums feeding the registered halves of the max trees.
  logic [NUM_STATES-1:0][SW-1:0] sum0, sum1;
  logic [2:0]                    st;

  always_comb begin
    sum0 = '0;
    sum1 = '0;
    st   = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      st      = 3'(s);
      sum0[s] = path_sum(s1_a[s], s1_g[{1'b0, parity(st, 1'b0)}], s1_b[next_state(st, 1'b0)]);
      sum1[s] = path_sum(s1_a[s], s1_g[{1'b1, parity(st, 1'b1)}], s1_b[next_state(st, 1'b1)]);
    end
  end

  logic signed [SW-1:0] max0, max1;

  max8_tree #(.W(SW)) u_max0 (.clk(clk), .rst(rst), .din(sum0), .dmax(max0));
  max8_tree #(.W(SW)) u_max1 (.clk(clk), .rst(rst), .din(sum1), .dmax(max1));

  logic              s2_valid, s2_last;
  logic [ADDR_W-1:0] s2_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_addr  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_addr <= s1_addr;
      end
    end
  end

  // S3: final max, subtract, reduce. hard_bit uses the full-width sign.
  logic signed [DW-1:0] diff;
  logic signed [MW-1:0] llr_red;
  logic                 hard_d;

  assign diff   = {max1[SW-1], max1} - {max0[SW-1], max0};
  assign hard_d = !diff[DW-1] && (diff != '0);

`ifdef LLR_SAT_EN
  localparam logic signed [DW-1:0] SAT_HI = {{(DW-MW+1){1'b0}}, {(MW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_LO = {{(DW-MW+1){1'b1}}, {(MW-1){1'b0}}};
`endif

  always_comb begin
    llr_red = '0;
`ifdef LLR_SAT_EN
    if (diff > SAT_HI)      llr_red = SAT_HI[MW-1:0];
    else if (diff < SAT_LO) llr_red = SAT_LO[MW-1:0];
    else                    llr_red = diff[MW-1:0];
`else
    llr_red = diff[MW-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llr       <= '0;
      hard_bit  <= 1'b0;
      llr_addr  <= '0;
      llr_valid <= 1'b0;
      done_llr  <= 1'b0;
    end else begin
      llr_valid <= s2_valid;
      done_llr  <= s2_valid & s2_last;
      if (s2_valid) begin
        llr      <= llr_red;
        hard_bit <= hard_d;
        llr_addr <= s2_addr;
      end
    end
  end

endmodule

// File: tb/tb_llr_stage.sv
// Directed bench for llr_stage: vector table through single-step blocks,
// plus back-to-back, mid-block reset and overrun sequences.
module tb_llr_stage;

  localparam int MW = 16;
  localparam int EW = 58;
  localparam int NV = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [7:0] count_main = '0;
  logic signed [MW-1:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic signed [MW-1:0] b0, b1, b2, b3, b4, b5, b6, b7;
  logic signed [MW-1:0] ls, lp;
  logic signed [MW-1:0] llr;
  logic hard_bit, llr_valid, done_llr, busy, err_overrun;
  logic [7:0] llr_addr;
  logic [1:0] fsm_state;

  llr_stage #(.MW(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .count_main(count_main),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7),
    .ls(ls), .lp(lp), .llr(llr), .hard_bit(hard_bit), .llr_valid(llr_valid),
    .llr_addr(llr_addr), .done_llr(done_llr), .busy(busy), .err_overrun(err_overrun),
    .fsm_state(fsm_state)
  );

  // Clock / cycle counter (cyc = posedges seen so far)
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0][15:0] a;
    logic [7:0][15:0] b;
    logic [15:0]      ls;
    logic [15:0]      lp;
    logic [15:0]      exp_llr;
    logic             exp_hard;
  } vec_t;

  vec_t vecs [NV];

  // Scoreboard entry: {cycle[31:0], llr[15:0], hard, addr[7:0], last}
  logic [EW-1:0] exp_q[$];
  logic [15:0]   hold_llr = '0;
  logic          hold_hard = 1'b0;
  logic [7:0]    hold_addr = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] vls, input logic [15:0] vlp,
                              input logic [15:0] vexp, input logic vhard);
    vec_t v;
    v = '0;
    v.ls = vls;
    v.lp = vlp;
    v.exp_llr = vexp;
    v.exp_hard = vhard;
    return v;
  endfunction

  // Driver tasks: called just after a negedge
  task automatic drive(input int vi, input logic [7:0] addr, input logic last, input logic expect_out);
    in_valid = 1'b1;
    in_last = last;
    count_main = addr;
    {a7, a6, a5, a4, a3, a2, a1, a0} = vecs[vi].a;
    {b7, b6, b5, b4, b3, b2, b1, b0} = vecs[vi].b;
    ls = vecs[vi].ls;
    lp = vecs[vi].lp;
    if (expect_out)
      exp_q.push_back({32'(cyc + 3), vecs[vi].exp_llr, vecs[vi].exp_hard, addr, last});
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Called mid-cycle (away from posedge)
  task automatic assert_reset();
    rst = 1'b0;
    idle();
    exp_q.delete();
    hold_llr = '0;
    hold_hard = 1'b0;
    hold_addr = '0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (llr_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'd0, llr_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", 32'(cyc), e[57:26]);
          chk("llr", {16'd0, llr}, {16'd0, e[25:10]});
          chk("hard_bit", {31'd0, hard_bit}, {31'd0, e[9]});
          chk("llr_addr", {24'd0, llr_addr}, {24'd0, e[8:1]});
          chk("done_llr", {31'd0, done_llr}, {31'd0, e[0]});
          hold_llr = e[25:10];
          hold_hard = e[9];
          hold_addr = e[8:1];
        end
      end else begin
        chk("done_without_valid", {31'd0, done_llr}, 32'd0);
        chk("hold_llr", {16'd0, llr}, {16'd0, hold_llr});
        chk("hold_hard", {31'd0, hard_bit}, {31'd0, hold_hard});
        chk("hold_addr", {24'd0, llr_addr}, {24'd0, hold_addr});
        if (exp_q.size() > 0 && exp_q[0][57:26] <= 32'(cyc)) begin
          chk("missing_valid", {31'd0, llr_valid}, 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    // Vector table, expected values worked out by hand
    vecs[0] = mk(16'd100, 16'd0, 16'd200, 1'b1);
    vecs[1] = mk(16'(-50), 16'd30, 16'(-100), 1'b0);
`ifdef LLR_SAT_EN
    vecs[2] = mk(16'd32767, 16'd32767, 16'h7FFF, 1'b1);
    vecs[3] = mk(16'(-32767), 16'd32767, 16'h8000, 1'b0);
`else
    vecs[2] = mk(16'd32767, 16'd32767, 16'hFFFE, 1'b1);
    vecs[3] = mk(16'(-32767), 16'd32767, 16'h0002, 1'b0);
`endif
    vecs[4] = mk(16'd0, 16'd50, 16'd0, 1'b0);
    vecs[5] = mk(16'd0, 16'd0, 16'd1000, 1'b1);
    vecs[5].a[0] = 16'd1000;
    vecs[5].b[1] = 16'd1000;
    vecs[6] = mk(16'd0, 16'd0, 16'(-1000), 1'b0);
    vecs[6].a[5] = 16'd1000;
    vecs[6].b[3] = 16'd1000;
    vecs[7] = mk(16'd0, 16'd100, 16'd200, 1'b1);
    vecs[8] = mk(16'd0, 16'd100, 16'(-200), 1'b0);
    for (int s = 0; s < 8; s++) begin
      vecs[7].a[s] = 16'(-5000);
      vecs[8].a[s] = 16'(-5000);
    end
    vecs[7].a[0] = 16'd5000;
    vecs[8].a[6] = 16'd5000;

    {a7, a6, a5, a4, a3, a2, a1, a0} = '0;
    {b7, b6, b5, b4, b3, b2, b1, b0} = '0;
    ls = '0;
    lp = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_overrun}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, 32'd0);
    #2 rst = 1'b1;

    // Single-step blocks (IDLE -> FLUSH directly)
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(i, 8'(i), 1'b1, 1'b1);
      @(negedge clk);
      idle();
      chk("flush_busy", {31'd0, busy}, 32'd1);
      chk("flush_state", {30'd0, fsm_state}, 32'd2);
      wait_idle();
    end

    // Eight back-to-back steps
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(i, 8'(i), (i == 7), 1'b1);
      if (i == 3) chk("run_state", {30'd0, fsm_state}, 32'd1);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("no_overrun_yet", {31'd0, err_overrun}, 32'd0);

    // Reset at step 4 of 8
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(i, 8'(40 + i), 1'b0, 1'b1);
    end
    #2 assert_reset();
    #1;
    chk("async_valid", {31'd0, llr_valid}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_llr", {16'd0, llr}, 32'd0);
    chk("async_addr", {24'd0, llr_addr}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_state", {30'd0, fsm_state}, 32'd0);
    @(negedge clk);
    drive(1, 8'd10, 1'b0, 1'b1);
    @(negedge clk);
    drive(5, 8'd11, 1'b0, 1'b1);
    @(negedge clk);
    drive(8, 8'd12, 1'b1, 1'b1);
    @(negedge clk);
    idle();
    wait_idle();

    // Overrun: in_valid the cycle after in_last
    @(negedge clk);
    drive(0, 8'd20, 1'b1, 1'b1);
    @(negedge clk);
    drive(6, 8'd21, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    chk("overrun_set", {31'd0, err_overrun}, 32'd1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("overrun_sticky", {31'd0, err_overrun}, 32'd1);
    #2 assert_reset();
    #1;
    chk("overrun_cleared", {31'd0, err_overrun}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    repeat (10) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
